// File: rtl/fsm_pkg.sv
// Shared constants and width helper for the ring sequencer family.
package fsm_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;

    // State width: ceil(log2(n)), never below one bit.
    function automatic int calc_sw(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update, sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ring_seq_fsm.sv
// N-state up/down ring sequencer with wrap/saturate ends, registered target match and entry count.
// One-cycle latency from STATE reaching TARGET to MATCH; WRAP pulses the cycle after a wrap step.
module ring_seq_fsm
    import fsm_pkg::*;
#(
    parameter int N_STATES = 4,
    parameter int CNT_W    = 8,
    localparam int SW      = calc_sw(N_STATES)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             IN,
    input  logic             MODE,
    input  logic             CLR,
    input  logic [SW-1:0]    TARGET,
    output logic [SW-1:0]    STATE,
    output logic             MATCH,
    output logic             WRAP,
    output logic [CNT_W-1:0] MATCH_CNT
);

    // One extra bit so N_STATES itself is representable (e.g. 256 with SW=8).
    localparam logic [SW:0]   N_EXT = (SW + 1)'(N_STATES);
    localparam logic [SW-1:0] LAST  = SW'(N_STATES - 1);

    logic [SW-1:0] state_q, state_d;
    logic          match_q, match_d;
    logic          wrap_q,  wrap_d;
    logic          hit;
    logic          illegal;

    assign illegal = ({1'b0, state_q} >= N_EXT);
    assign hit     = (state_q == TARGET) && ({1'b0, TARGET} < N_EXT);

    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        match_d = CLR ? 1'b0 : hit;
        if (CLR || illegal) begin
            state_d = '0;
        end else if (EN) begin
            if (IN == DIR_UP) begin
                if (state_q == LAST) begin
                    if (MODE == MODE_WRAP) begin
                        state_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    state_d = state_q + 1'b1;
                end
            end else begin
                if (state_q == '0) begin
                    if (MODE == MODE_WRAP) begin
                        state_d = LAST;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    state_d = state_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= '0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
        end
    end

    // Count rising entries into the target, not dwell cycles.
    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .CLK (CLK),
        .RST (RST),
        .clr (CLR),
        .inc (hit && !match_q),
        .cnt (MATCH_CNT)
    );

    assign STATE = state_q;
    assign MATCH = match_q;
    assign WRAP  = wrap_q;

endmodule

// File: tb/tb_ring_seq_fsm.sv
// Directed bench for ring_seq_fsm across four parameter sets.
module tb_ring_seq_fsm;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Instance A: N=4, CNT_W=8
    logic       a_en = 0, a_in = 0, a_clr = 0;
    logic [1:0] a_tgt = 2'd3, a_st;
    logic       a_m, a_w;
    logic [7:0] a_c;
    ring_seq_fsm #(.N_STATES(4), .CNT_W(8)) u_a (
        .CLK(CLK), .RST(RST), .EN(a_en), .IN(a_in), .MODE(1'b0), .CLR(a_clr),
        .TARGET(a_tgt), .STATE(a_st), .MATCH(a_m), .WRAP(a_w), .MATCH_CNT(a_c));

    // Instance B: N=5, saturate mode
    logic       b_en = 0, b_in = 0;
    logic [2:0] b_st;
    logic       b_m, b_w;
    logic [7:0] b_c;
    ring_seq_fsm #(.N_STATES(5), .CNT_W(8)) u_b (
        .CLK(CLK), .RST(RST), .EN(b_en), .IN(b_in), .MODE(1'b1), .CLR(1'b0),
        .TARGET(3'd4), .STATE(b_st), .MATCH(b_m), .WRAP(b_w), .MATCH_CNT(b_c));

    // Instance C: N=6, out-of-range target
    logic       c_en = 0, c_in = 0;
    logic [2:0] c_st;
    logic       c_m, c_w;
    logic [7:0] c_c;
    ring_seq_fsm #(.N_STATES(6), .CNT_W(8)) u_c (
        .CLK(CLK), .RST(RST), .EN(c_en), .IN(c_in), .MODE(1'b0), .CLR(1'b0),
        .TARGET(3'd7), .STATE(c_st), .MATCH(c_m), .WRAP(c_w), .MATCH_CNT(c_c));

    // Instance D: N=2, CNT_W=2
    logic       d_en = 0;
    logic [0:0] d_st;
    logic       d_m, d_w;
    logic [1:0] d_c;
    ring_seq_fsm #(.N_STATES(2), .CNT_W(2)) u_d (
        .CLK(CLK), .RST(RST), .EN(d_en), .IN(1'b1), .MODE(1'b0), .CLR(1'b0),
        .TARGET(1'b1), .STATE(d_st), .MATCH(d_m), .WRAP(d_w), .MATCH_CNT(d_c));

    typedef struct {
        logic       en, in, clr;
        logic [1:0] tgt;
        logic [1:0] s;
        logic       m, w;
        logic [7:0] c;
    } vec_t;
    vec_t vq[$];

    task automatic push(input logic en, input logic in, input logic clr, input logic [1:0] tgt,
                        input logic [1:0] s, input logic m, input logic w, input logic [7:0] c);
        vec_t v;
        v.en = en; v.in = in; v.clr = clr; v.tgt = tgt;
        v.s = s; v.m = m; v.w = w; v.c = c;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        // en in clr tgt | state match wrap cnt
        push(1,0,0,3, 3,0,1,0);
        push(1,1,0,3, 0,1,1,1);
        push(1,1,0,3, 1,0,0,1);
        push(1,1,0,3, 2,0,0,1);
        push(1,0,0,3, 1,0,0,1);
        push(1,1,0,3, 2,0,0,1);
        push(0,1,0,3, 2,0,0,1);
        push(0,1,0,3, 2,0,0,1);
        push(0,1,0,3, 2,0,0,1);
        push(1,1,1,3, 0,0,0,0);
        push(0,0,0,0, 0,1,0,1);
        push(0,0,0,0, 0,1,0,1);
        push(1,0,0,3, 3,0,1,1);
        push(1,1,0,3, 0,1,1,2);
        push(1,0,0,3, 3,0,1,2);
        push(0,0,0,3, 3,1,0,3);
        push(1,1,1,3, 0,0,0,0);
        push(1,0,0,3, 3,0,1,0);
        push(0,0,0,3, 3,1,0,1);

        #2;
        chk("rst_state", 0, a_st, 0);
        chk("rst_match", 0, a_m, 0);
        chk("rst_wrap",  0, a_w, 0);
        chk("rst_cnt",   0, a_c, 0);
        #10 RST = 1'b0;
        a_en = vq[0].en; a_in = vq[0].in; a_clr = vq[0].clr; a_tgt = vq[0].tgt;

        foreach (vq[i]) begin
            a_en = vq[i].en; a_in = vq[i].in; a_clr = vq[i].clr; a_tgt = vq[i].tgt;
            step();
            chk("a_state", i, a_st, vq[i].s);
            chk("a_match", i, a_m,  vq[i].m);
            chk("a_wrap",  i, a_w,  vq[i].w);
            chk("a_cnt",   i, a_c,  vq[i].c);
        end
        a_en = 0; a_clr = 0;

        // Async reset between edges with STATE=3, MATCH=1
        #1 RST = 1'b1;
        #1;
        chk("arst_state", 0, a_st, 0);
        chk("arst_match", 0, a_m, 0);
        chk("arst_cnt",   0, a_c, 0);
        #2 RST = 1'b0;
        a_en = 1; a_in = 1; a_tgt = 2'd3;
        step();
        chk("resume_state", 0, a_st, 1);
        chk("resume_match", 0, a_m, 0);
        chk("resume_wrap",  0, a_w, 0);
        a_en = 0;

        // Saturation: one down step at 0, then seven up steps
        begin
            logic [2:0] es [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
            logic       em [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
            b_en = 1;
            for (int i = 0; i < 8; i++) begin
                b_in = (i != 0);
                step();
                chk("b_state", i, b_st, es[i]);
                chk("b_match", i, b_m, em[i]);
                chk("b_wrap",  i, b_w, 0);
                chk("b_cnt",   i, b_c, em[i]);
            end
            b_en = 0;
        end

        // Out-of-range target with alternating wrap steps
        c_en = 1;
        for (int i = 0; i < 20; i++) begin
            c_in = i[0];
            step();
            chk("c_state", i, c_st, (i % 2 == 0) ? 5 : 0);
            chk("c_match", i, c_m, 0);
            chk("c_wrap",  i, c_w, 1);
            chk("c_cnt",   i, c_c, 0);
        end
        c_en = 0;

        // Two-state toggle with 2-bit saturating counter
        d_en = 1;
        for (int i = 1; i <= 12; i++) begin
            int ec;
            ec = (i / 2 > 3) ? 3 : i / 2;
            step();
            chk("d_state", i, d_st, i % 2);
            chk("d_match", i, d_m, (i % 2 == 0));
            chk("d_wrap",  i, d_w, (i % 2 == 0));
            chk("d_cnt",   i, d_c, ec);
        end
        d_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
